// File: rtl/enum_t.sv
// -----------------------------------------------------------------------------
// enum_t -- types shared between the I2C byte engine and its controllers.
//   i2c_t : engine phase reported on i2c_master.st
//   en_t  : command driven by the controller on i2c_master.en
// -----------------------------------------------------------------------------
package enum_t;

  typedef enum logic [2:0] {STOP, START, WR, ACK, NACK, RD, Z} i2c_t;

  typedef enum logic [1:0] {EN_STOP, EN_WR, EN_RD} en_t;

  // Bit indices inside a 9-bit byte frame (bit 0 is sent first, MSB of data).
  localparam int unsigned LAST_DATA_BIT = 7;
  localparam int unsigned ACK_BIT       = 8;

endpackage

// File: rtl/i2c_qtr_tick.sv
// -----------------------------------------------------------------------------
// i2c_qtr_tick -- free-running quarter-bit timebase.
//   clk, rst_n : system clock, async active-low reset
//   tick       : one-cycle strobe every QTR clk cycles (QTR >= 4)
// -----------------------------------------------------------------------------
module i2c_qtr_tick #(
  parameter int unsigned QTR = 125
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(QTR - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  // NOTE: state flops use non-blocking assignment so every flop samples the
  // pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/i2c_master.sv
// -----------------------------------------------------------------------------
// i2c_master -- byte-level I2C bus master engine.
//   clk, rst_n : system clock, async active-low reset
//   sda        : open-drain data line (drives 0 or 'z only)
//   sclk       : SCL, push-pull, high when idle
//   data       : byte to transmit, latched at the start of each write byte
//   en         : controller command (EN_STOP / EN_WR / EN_RD)
//   st         : engine phase (STOP START WR ACK NACK RD Z)
//   out_i2c    : last received byte, valid while st == Z
// Every bit is four quarters q0..q3: SCL low in q0-q1 and high in q2-q3,
// SDA changes only at the start of q1 and is sampled at the end of q2.
// -----------------------------------------------------------------------------
module i2c_master
  import enum_t::*;
#(
  parameter int unsigned QTR = 125
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        sda,
  output logic       sclk,
  input  logic [7:0] data,
  input  en_t        en,
  output i2c_t       st,
  output logic [7:0] out_i2c
);

  logic tick;

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  i2c_t       st_q, st_d;
  logic [1:0] qtr_q, qtr_d;      // current quarter within the bit
  logic [3:0] bit_q, bit_d;      // bit index within the 9-bit frame
  logic [7:0] shift_q, shift_d;
  logic [7:0] out_q, out_d;
  logic       oe_q, oe_d;        // 1 = pull SDA low
  logic       scl_q, scl_d;
  logic       stop_q, stop_d;    // STOP sequence in progress; st holds old phase
  logic       nack_q, nack_d;    // slave ACK bit as sampled
  logic       sda_s1_q, sda_s2_q;

  wire sda_in = sda_s2_q;

  always_comb begin
    st_d    = st_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    out_d   = out_q;
    oe_d    = oe_q;
    scl_d   = scl_q;
    stop_d  = stop_q;
    nack_d  = nack_q;

    if (tick) begin
      qtr_d = qtr_q + 2'd1;
      if (stop_q) begin
        // q1 SDA low, q2 SCL high, release SDA at the end of q3.
        unique case (qtr_q)
          2'd0: oe_d  = 1'b1;
          2'd1: scl_d = 1'b1;
          2'd2: ;
          2'd3: begin
            oe_d   = 1'b0;
            stop_d = 1'b0;
            st_d   = STOP;
          end
        endcase
      end else begin
        unique case (st_q)
          STOP: begin
            qtr_d = qtr_q;
            if (en != EN_STOP) begin
              // START: SDA falls while SCL is high for q2..q3.
              st_d    = START;
              oe_d    = 1'b1;
              shift_d = data;
              qtr_d   = 2'd2;
            end
          end
          START: begin
            if (qtr_q == 2'd3) begin
              st_d  = WR;
              scl_d = 1'b0;
              bit_d = '0;
            end
          end
          WR: begin
            unique case (qtr_q)
              2'd0: begin
                oe_d    = (bit_q == 4'(ACK_BIT)) ? 1'b0 : ~shift_q[7];
                shift_d = {shift_q[6:0], 1'b0};
              end
              2'd1: scl_d = 1'b1;
              2'd2: if (bit_q == 4'(ACK_BIT)) nack_d = sda_in;
              2'd3: begin
                scl_d = 1'b0;
                if (bit_q == 4'(ACK_BIT)) begin
                  st_d  = nack_q ? NACK : ACK;
                  bit_d = '0;
                end else begin
                  bit_d = bit_q + 4'd1;
                end
              end
            endcase
          end
          ACK: begin
            // One quarter (q0); the next phase starts directly at q1.
            unique case (en)
              EN_WR: begin
                st_d    = WR;
                bit_d   = '0;
                oe_d    = ~data[7];
                shift_d = {data[6:0], 1'b0};
              end
              EN_RD: begin
                st_d  = RD;
                bit_d = '0;
                oe_d  = 1'b0;
              end
              default: begin
                stop_d = 1'b1;
                oe_d   = 1'b1;
              end
            endcase
          end
          NACK: begin
            stop_d = 1'b1;
            oe_d   = 1'b1;
          end
          RD: begin
            unique case (qtr_q)
              2'd0: oe_d    = 1'b0;
              2'd1: scl_d   = 1'b1;
              2'd2: shift_d = {shift_q[6:0], sda_in};
              2'd3: begin
                scl_d = 1'b0;
                if (bit_q == 4'(LAST_DATA_BIT)) begin
                  out_d = shift_q;
                  st_d  = Z;
                  bit_d = '0;
                end else begin
                  bit_d = bit_q + 4'd1;
                end
              end
            endcase
          end
          Z: begin
            // The master ACK decision lives in oe_q from q1 onward and also
            // selects what follows the bit.
            unique case (qtr_q)
              2'd0: oe_d  = (en == EN_RD);
              2'd1: scl_d = 1'b1;
              2'd2: ;
              2'd3: begin
                scl_d = 1'b0;
                bit_d = '0;
                if (oe_q) st_d   = RD;
                else      stop_d = 1'b1;
              end
            endcase
          end
          default: st_d = STOP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= STOP;
      qtr_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      out_q    <= '0;
      oe_q     <= 1'b0;
      scl_q    <= 1'b1;
      stop_q   <= 1'b0;
      nack_q   <= 1'b0;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      st_q     <= st_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      scl_q    <= scl_d;
      stop_q   <= stop_d;
      nack_q   <= nack_d;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
    end
  end

  assign sda     = oe_q ? 1'b0 : 1'bz;
  assign sclk    = scl_q;
  assign st      = st_q;
  assign out_i2c = out_q;

endmodule

// File: tb/tb_i2c_master.sv
// -----------------------------------------------------------------------------
// tb_i2c_master -- directed bench for i2c_master with a bus-level slave model.
// -----------------------------------------------------------------------------
module tb_i2c_master;
  import enum_t::*;

  localparam int unsigned QTR    = 4;
  localparam int          BUDGET = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  wire        sda;
  logic       sclk;
  logic [7:0] data;
  en_t        en;
  i2c_t       st;
  logic [7:0] out_i2c;

  int n_checks = 0;
  int n_pass   = 0;

  // Slave / bus monitor state (written only by the monitor process).
  logic       slv_low = 1'b0;
  logic       ack_en;
  logic [7:0] rd_data [2];
  logic       prev_sc = 1'b1, prev_sd = 1'b1;
  logic       active = 1'b0, slave_tx = 1'b0;
  int         nbit = 0, frame = 0, rise_cnt = 0, rd_idx = 0;
  int         n_start = 0, n_stop = 0;
  logic [7:0] rx_byte = '0, tx_byte = '0;
  logic [7:0] wr_q [$];
  logic       mack_q [$];
  time        last_rise = 0, period_t = 0, high_t = 0;
  i2c_t       st_prev = STOP;
  i2c_t       log_q [$];
  int         run = 0, ack_first_len = 0, z_first_len = 0;
  logic       ack_seen = 1'b0, z_seen = 1'b0;

  pullup (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_master #(.QTR(QTR)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sda    (sda),
    .sclk   (sclk),
    .data   (data),
    .en     (en),
    .st     (st),
    .out_i2c(out_i2c)
  );

  // Bus-level slave: ACKs written bytes when ack_en, and after an address
  // with LSB=1 returns rd_data bytes for as long as the master ACKs.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_sc <= 1'b1;
      prev_sd <= 1'b1;
      active  <= 1'b0;
      slv_low <= 1'b0;
      st_prev <= STOP;
      run     <= 0;
    end else begin
      if (sclk && prev_sc && prev_sd && !sda) begin
        n_start  <= n_start + 1;
        nbit     <= 0;
        frame    <= 0;
        rise_cnt <= 0;
        rd_idx   <= 0;
        active   <= 1'b1;
        slave_tx <= 1'b0;
        slv_low  <= 1'b0;
        wr_q.delete();
        mack_q.delete();
      end else if (sclk && prev_sc && !prev_sd && sda) begin
        n_stop  <= n_stop + 1;
        active  <= 1'b0;
        slv_low <= 1'b0;
      end else if (active && sclk && !prev_sc) begin
        rise_cnt  <= rise_cnt + 1;
        last_rise <= $time;
        if (rise_cnt == 2) period_t <= $time - last_rise;
        if (nbit < 8) begin
          if (!slave_tx) rx_byte <= {rx_byte[6:0], sda};
          nbit <= nbit + 1;
        end else begin
          nbit  <= 0;
          frame <= frame + 1;
          if (!slave_tx) begin
            wr_q.push_back(rx_byte);
            if (frame == 0 && rx_byte[0]) begin
              slave_tx <= 1'b1;
              tx_byte  <= rd_data[rd_idx];
              rd_idx   <= rd_idx + 1;
            end
          end else begin
            mack_q.push_back(!sda);
            if (!sda && rd_idx < 2) begin
              tx_byte <= rd_data[rd_idx];
              rd_idx  <= rd_idx + 1;
            end else begin
              slave_tx <= 1'b0;
            end
          end
        end
      end else if (active && !sclk && prev_sc) begin
        if (rise_cnt == 3) high_t <= $time - last_rise;
        if (slave_tx) slv_low <= (nbit < 8) ? !tx_byte[3'(7 - nbit)] : 1'b0;
        else          slv_low <= (nbit == 8) ? ack_en : 1'b0;
      end
      prev_sc <= sclk;
      prev_sd <= sda;

      // Phase log of st, restarted at every START.
      if (st != st_prev) begin
        if (st_prev == ACK && !ack_seen) begin
          ack_first_len <= run;
          ack_seen      <= 1'b1;
        end
        if (st_prev == Z && !z_seen) begin
          z_first_len <= run;
          z_seen      <= 1'b1;
        end
        if (st == START) begin
          log_q.delete();
          log_q.push_back(STOP);
          ack_seen <= 1'b0;
          z_seen   <= 1'b0;
        end
        log_q.push_back(st);
        run     <= 1;
        st_prev <= st;
      end else begin
        run <= run + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_st(input i2c_t s, input string tag);
    for (int i = 0; i < BUDGET; i++) begin
      @(posedge clk);
      #1;
      if (st == s) break;
    end
    check(tag, 32'(st), 32'(s));
  endtask

  task automatic check_log(input string tag, input i2c_t exp_q[$]);
    check({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < log_q.size()) check($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_len"}, 32'(wr_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < wr_q.size()) check($sformatf("%s_%0d", tag, i), 32'(wr_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    i2c_t       exp_st [$];
    logic [7:0] exp_b  [$];

    rst_n      = 1'b0;
    en         = EN_STOP;
    data       = 8'h00;
    ack_en     = 1'b1;
    rd_data[0] = 8'h3C;
    rd_data[1] = 8'hC3;

    // Reset state.
    #23;
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_st", 32'(st), 32'(STOP));
    check("rst_out", 32'(out_i2c), 32'd0);
    #9 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("idle_hold", 32'(st), 32'(STOP));

    // Write A0, 00, 55 with slave ACKs, then stop.
    data = 8'hA0;
    en   = EN_WR;
    wait_st(START, "wr_start");
    wait_st(ACK, "wr_ack0");
    data = 8'h00;
    wait_st(WR, "wr_byte1");
    wait_st(ACK, "wr_ack1");
    data = 8'h55;
    wait_st(WR, "wr_byte2");
    wait_st(ACK, "wr_ack2");
    en = EN_STOP;
    wait_st(STOP, "wr_idle");
    repeat (4) @(posedge clk);
    #1;
    exp_b = '{8'hA0, 8'h00, 8'h55};
    check_bytes("wr_bytes", exp_b);
    exp_st = '{STOP, START, WR, ACK, WR, ACK, WR, ACK, STOP};
    check_log("wr_seq", exp_st);
    check("wr_ack_len", 32'(ack_first_len), 32'(QTR));
    check("scl_period", 32'(period_t), 32'(16 * 10));
    check("scl_high", 32'(high_t), 32'(8 * 10));
    check("wr_starts", 32'(n_start), 32'd1);
    check("wr_stops", 32'(n_stop), 32'd1);

    // Slave NACK on the address byte aborts with STOP.
    ack_en = 1'b0;
    data   = 8'hA0;
    en     = EN_WR;
    wait_st(START, "nk_start");
    wait_st(NACK, "nk_nack");
    en = EN_STOP;
    wait_st(STOP, "nk_idle");
    repeat (4) @(posedge clk);
    #1;
    ack_en = 1'b1;
    exp_b  = '{8'hA0};
    check_bytes("nk_bytes", exp_b);
    exp_st = '{STOP, START, WR, NACK, STOP};
    check_log("nk_seq", exp_st);
    check("nk_stops", 32'(n_stop), 32'd2);

    // Read two bytes after address A1; master ACKs the first, NACKs the second.
    data = 8'hA1;
    en   = EN_RD;
    wait_st(START, "rd_start");
    wait_st(ACK, "rd_addr_ack");
    wait_st(RD, "rd_byte0");
    wait_st(Z, "rd_z0");
    check("rd_out0", 32'(out_i2c), 32'h3C);
    wait_st(RD, "rd_byte1");
    wait_st(Z, "rd_z1");
    check("rd_out1", 32'(out_i2c), 32'hC3);
    @(posedge clk);
    #1 en = EN_STOP;
    wait_st(STOP, "rd_idle");
    repeat (4) @(posedge clk);
    #1;
    exp_b = '{8'hA1};
    check_bytes("rd_addr", exp_b);
    exp_st = '{STOP, START, WR, ACK, RD, Z, RD, Z, STOP};
    check_log("rd_seq", exp_st);
    check("rd_mack_len", 32'(mack_q.size()), 32'd2);
    if (mack_q.size() == 2) begin
      check("rd_mack0", 32'(mack_q[0]), 32'd1);
      check("rd_mack1", 32'(mack_q[1]), 32'd0);
    end
    check("rd_z_len", 32'(z_first_len), 32'(4 * QTR));
    check("rd_stops", 32'(n_stop), 32'd3);

    // Reset in the middle of a write byte (bit 1 of A0 holds SDA low).
    data = 8'hA0;
    en   = EN_WR;
    wait_st(WR, "mid_wr");
    repeat (20) @(posedge clk);
    #1;
    check("mid_pre_scl", 32'(sclk), 32'd0);
    check("mid_pre_sda", 32'(sda), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_scl", 32'(sclk), 32'd1);
    check("mid_rst_sda", 32'(sda), 32'd1);
    check("mid_rst_st", 32'(st), 32'(STOP));
    en = EN_STOP;
    #20 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("post_rst_idle", 32'(st), 32'(STOP));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
